// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter: shares one memory port between instruction fetch and data.
// Optional macro ARB_STARVE_GUARD_EN forces a fetch grant after 3 data grants.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   resp_fetch;
  logic   resp_err;
  logic   grant_fetch;
  logic   grant_data;
  logic   misaligned;
  logic   starve;
  logic   done;

  assign misaligned = (d_addr[1:0] != 2'b00);
  assign done       = ((state == FETCH) || (state == DATA)) && mem_ready;

`ifdef ARB_STARVE_GUARD_EN
  // Saturating count of data grants made while fetch was also waiting.
  logic [1:0] starve_cnt;
  assign starve = (starve_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 2'd0;
    end else if (grant_fetch) begin
      starve_cnt <= 2'd0;
    end else if (grant_data && if_req && !starve) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(starve && if_req)) begin
          grant_data = 1'b1;
          state_nx   = misaligned ? RESP : DATA;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_nx    = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr   <= 32'd0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'd0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
      resp_fetch <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (grant_data) begin
        resp_fetch <= 1'b0;
        resp_err   <= misaligned;
        // A misaligned request never reaches the bus, so leave it untouched.
        if (!misaligned) begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_wdata;
        end
      end else if (grant_fetch) begin
        resp_fetch <= 1'b1;
        resp_err   <= 1'b0;
        mem_addr   <= if_addr;
        mem_we     <= 1'b0;
      end
      if (done) begin
        mem_we <= 1'b0;
        if (state == FETCH) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req = (state == FETCH) || (state == DATA);
  assign if_ack  = (state == RESP) && resp_fetch;
  assign d_ack   = (state == RESP) && !resp_fetch;
  assign d_err   = (state == RESP) && resp_err;
  assign stall   = (if_req && !if_ack) || (d_req && !d_ack);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the instruction-fetch requester ports if_req (in, 1), if_addr (in, 32), if_rdata (out, 32) and if_ack (out, 1).
REQ-004 The block SHALL have the data requester ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_rdata (out, 32), d_ack (out, 1) and d_err (out, 1).
REQ-005 The block SHALL have the memory ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32) and mem_ready (in, 1).
REQ-006 The block SHALL have the port stall, output, 1 bit: the processor hold request.

Function
REQ-007 The block SHALL share one memory port between fetch and data via FSM states IDLE, FETCH, DATA and RESP.
REQ-008 In IDLE, at a rising edge with d_req high and d_addr[1:0]==0, the block SHALL latch d_addr, d_we and d_wdata, then enter DATA.
REQ-009 In IDLE, at a rising edge with d_req high and d_addr[1:0]!=0, the block SHALL enter RESP with d_err and d_ack pulsed, and mem_req SHALL stay low.
REQ-010 In IDLE, with d_req low and if_req high, the block SHALL latch if_addr, force mem_we low, and enter FETCH.
REQ-011 When d_req and if_req are both high in IDLE, the block SHALL grant data, except as stated in REQ-022.
REQ-012 In FETCH and DATA, mem_req SHALL be high and mem_addr, mem_we and mem_wdata SHALL drive the latched values, held stable until mem_ready is sampled high.
REQ-013 When mem_ready is sampled high in FETCH or DATA, the block SHALL register mem_rdata into if_rdata or d_rdata respectively and enter RESP.
REQ-014 On leaving FETCH or DATA, mem_req SHALL go low.
REQ-015 In RESP, the block SHALL hold the matching ack high for exactly one cycle, grant nothing, and return to IDLE.
REQ-016 if_rdata and d_rdata SHALL hold their last value until the next completion of the same type.
REQ-017 Each requester SHALL hold its req and its address/data inputs until its ack, and SHALL drop req in the cycle after ack.
REQ-018 Request-to-ack latency SHALL be the number of wait cycles plus 2, with a minimum of 2 cycles (req at edge N, ack high during cycle N+2 when mem_ready is high in the first busy cycle).
REQ-019 stall SHALL equal (if_req AND NOT if_ack) OR (d_req AND NOT d_ack), combinationally.
REQ-020 mem_ready sampled in IDLE or RESP SHALL be ignored.

Reset
REQ-021 While reset is low, the block SHALL be in IDLE with mem_req, mem_we, if_ack, d_ack and d_err low, mem_addr, mem_wdata, if_rdata and d_rdata at 0, and the starvation counter at 0; assertion mid-access SHALL drop mem_req immediately and abandon the access with no ack.

Configuration
REQ-022 With ARB_STARVE_GUARD_EN defined, a 2-bit counter SHALL count consecutive data grants made while if_req is high; at count 3, the next IDLE grant SHALL go to fetch, even with d_req high.
REQ-023 With ARB_STARVE_GUARD_EN defined, the counter SHALL clear on any fetch grant, and it SHALL hold at 3 rather than wrap.
REQ-024 Without ARB_STARVE_GUARD_EN, the block SHALL contain no counter and data priority SHALL be strict.

Verification
REQ-025 The bench SHALL drive a single fetch with if_addr=0x00400000, mem_ready high, mem_rdata=0x8C080004, and SHALL check that mem_req is high for 1 cycle, if_ack is high in cycle +2, and if_rdata=0x8C080004.
REQ-026 The bench SHALL raise d_req (store of 0x000000AA to 0x10010004) and if_req in the same cycle, and SHALL check that the data access completes first with mem_we=1 and that fetch is granted on the first IDLE after RESP.
REQ-027 The bench SHALL hold mem_ready low for 3 busy cycles, and SHALL check that mem_addr is stable throughout, that ack arrives at cycle +5, and that stall stays high until then.
REQ-028 The bench SHALL drive d_req with d_addr=0x10010002, and SHALL check that d_err and d_ack are high for one cycle and that mem_req is never asserted.
REQ-029 The bench SHALL drop reset during DATA, and SHALL check that mem_req falls with no clock edge, no ack occurs, and the block is in IDLE after release.
REQ-030 With ARB_STARVE_GUARD_EN defined, the bench SHALL keep d_req and if_req continuously high, and SHALL check the grant order D,D,D,F; without the macro, it SHALL check that fetch is never granted.
